// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO: Gray/binary
// pointer conversion and the output buffer sizing constants.
package fifo_pkg;

    // Number of words the read-side first-word-fall-through buffer holds.
    localparam int FIFO_OBUF_DEPTH = 2;
    // Width of a counter able to hold 0..FIFO_OBUF_DEPTH.
    localparam int FIFO_OBUF_CW    = $clog2(FIFO_OBUF_DEPTH + 1);

    // Conversions work on a wide container. Callers zero-extend an
    // AW+1-bit pointer into it and truncate the result back to AW+1 bits;
    // the zero upper bits never disturb the low bits of either conversion.
    localparam int FIFO_PTR_MAXW = 32;
    typedef logic [FIFO_PTR_MAXW-1:0] fifo_ptr_t;

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray);
        fifo_ptr_t bin;
        bin[FIFO_PTR_MAXW-1] = gray[FIFO_PTR_MAXW-1];
        for (int i = FIFO_PTR_MAXW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry first-word-fall-through output buffer (head + skid).
// The head register is what the consumer sees; the skid register absorbs
// the word that arrives from RAM while the head is still waiting.
module fifo_rd_obuf
    import fifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DW-1:0]           data_in,
    input  logic                    pop,
    output logic [FIFO_OBUF_CW-1:0] cnt,
    output logic [DW-1:0]           head_data,
    output logic                    head_valid
);

    localparam int CW = FIFO_OBUF_CW;

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_skid;
    logic [CW-1:0] r_cnt;
    logic          r_valid;

    logic [DW-1:0] w_head_next;
    logic [DW-1:0] w_skid_next;
    logic [CW-1:0] w_cnt_next;

    // Next-state of the buffer: pop shifts skid into head, push fills the
    // first free slot; both together keep order and leave the count alone.
    always_comb begin
        w_head_next = r_head;
        w_skid_next = r_skid;
        w_cnt_next  = r_cnt;
        case ({push, pop})
            2'b10: begin
                if (r_cnt == CW'(0)) begin
                    w_head_next = data_in;
                end else begin
                    w_skid_next = data_in;
                end
                w_cnt_next = r_cnt + CW'(1);
            end
            2'b01: begin
                if (r_cnt == CW'(2)) begin
                    w_head_next = r_skid;
                end
                w_cnt_next = r_cnt - CW'(1);
            end
            2'b11: begin
                if (r_cnt == CW'(1)) begin
                    w_head_next = data_in;
                end else begin
                    w_head_next = r_skid;
                    w_skid_next = data_in;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer registers; valid is registered alongside the head it qualifies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_skid  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_next;
            r_skid  <= w_skid_next;
            r_cnt   <= w_cnt_next;
            r_valid <= (w_cnt_next != '0);
        end
    end

    assign cnt        = r_cnt;
    assign head_data  = r_head;
    assign head_valid = r_valid;

endmodule

// File: rtl/fifo_rd.sv
// Read-side control of the asynchronous FIFO: binary/Gray read pointer,
// registered empty flag and memory level, RAM fetch control and the
// two-entry output buffer.
//
// Handshake: a word transfers on a rising I_RD_CLK edge where O_RD_VALID
// and I_RD_READY are both high. Once O_RD_VALID is high it stays high and
// O_RD_DATA stays stable until that transfer happens; I_RD_READY may be
// asserted or dropped at any time and has no combinational path to
// O_RD_VALID or O_RD_DATA.
module fifo_rd
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          I_RD_CLK,
    input  logic          I_RD_RST,
    input  logic [AW:0]   I_RD_WR_PTR,
    output logic [AW:0]   O_RD_PTR,
    output logic [AW-1:0] O_RD_ADDR,
    output logic          O_RD_MEM_EN,
    input  logic [DW-1:0] I_RD_MEM_DATA,
    output logic [DW-1:0] O_RD_DATA,
    output logic          O_RD_VALID,
    input  logic          I_RD_READY,
    output logic          O_RD_EMPTY,
    output logic [AW:0]   O_RD_LEVEL
);

    localparam int PW  = AW + 1;
    localparam int OCW = FIFO_OBUF_CW + 1;
    localparam logic [OCW-1:0] OBUF_DEPTH = OCW'(FIFO_OBUF_DEPTH);

    logic [PW-1:0]           r_rd_bin;
    logic [PW-1:0]           r_rd_gray;
    logic [PW-1:0]           r_level;
    logic                    r_empty;
    logic                    r_inflight;

    logic [PW-1:0]           w_rd_bin_next;
    logic [PW-1:0]           w_rd_gray_next;
    logic [PW-1:0]           w_wr_bin;
    logic [PW-1:0]           w_level_next;
    logic [OCW-1:0]          w_occ;
    logic                    w_fetch;
    logic                    w_pop;
    logic [FIFO_OBUF_CW-1:0] w_cnt;
    logic                    w_obuf_valid;
    logic [DW-1:0]           w_obuf_data;

    // Fetch decision and next pointers. A fetch is issued only if the word
    // will have a buffer slot after this cycle's pop, counting the word
    // already on its way back from RAM.
    always_comb begin
        w_pop          = w_obuf_valid & I_RD_READY;
        w_occ          = {1'b0, w_cnt}
                       + {{(OCW-1){1'b0}}, r_inflight}
                       - {{(OCW-1){1'b0}}, w_pop};
        w_fetch        = ~r_empty & (w_occ < OBUF_DEPTH);
        w_rd_bin_next  = r_rd_bin + {{AW{1'b0}}, w_fetch};
        w_rd_gray_next = PW'(bin2gray(FIFO_PTR_MAXW'(w_rd_bin_next)));
        w_wr_bin       = PW'(gray2bin(FIFO_PTR_MAXW'(I_RD_WR_PTR)));
        w_level_next   = w_wr_bin - w_rd_bin_next;
    end

    // Pointer, empty, level and in-flight registers. Empty compares Gray
    // codes directly, so pointer and address wrap need no special case.
    always_ff @(posedge I_RD_CLK or posedge I_RD_RST) begin
        if (I_RD_RST) begin
            r_rd_bin   <= '0;
            r_rd_gray  <= '0;
            r_empty    <= 1'b1;
            r_level    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_rd_bin   <= w_rd_bin_next;
            r_rd_gray  <= w_rd_gray_next;
            r_empty    <= (w_rd_gray_next == I_RD_WR_PTR);
            r_level    <= w_level_next;
            r_inflight <= w_fetch;
        end
    end

    fifo_rd_obuf #(
        .DW(DW)
    ) u_obuf (
        .clk        (I_RD_CLK),
        .rst        (I_RD_RST),
        .push       (r_inflight),
        .data_in    (I_RD_MEM_DATA),
        .pop        (w_pop),
        .cnt        (w_cnt),
        .head_data  (w_obuf_data),
        .head_valid (w_obuf_valid)
    );

    assign O_RD_PTR    = r_rd_gray;
    assign O_RD_ADDR   = r_rd_bin[AW-1:0];
    assign O_RD_MEM_EN = w_fetch;
    assign O_RD_DATA   = w_obuf_data;
    assign O_RD_VALID  = w_obuf_valid;
    assign O_RD_EMPTY  = r_empty;
    assign O_RD_LEVEL  = r_level;

endmodule

// File: tb/tb_fifo_rd.sv
// Bench for fifo_rd: the bench plays the write side and the RAM, pushes
// every written word into an expected queue, and a monitor pops and
// compares each word the DUT hands over.
module tb_fifo_rd;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          I_RD_RST = 1'b1;
  logic [AW:0]   I_RD_WR_PTR = '0;
  logic          I_RD_READY = 1'b0;
  logic [DW-1:0] ram_q = '0;
  logic [AW:0]   O_RD_PTR;
  logic [AW-1:0] O_RD_ADDR;
  logic          O_RD_MEM_EN;
  logic [DW-1:0] O_RD_DATA;
  logic          O_RD_VALID;
  logic          O_RD_EMPTY;
  logic [AW:0]   O_RD_LEVEL;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   wr_bin = '0;
  int            wr_total = 0;
  int            fetch_cnt = 0;
  int            pop_cnt = 0;
  int            n_cmp = 0;
  int            n_mis = 0;
  logic          rand_ready = 1'b0;
  logic          ready_val = 1'b0;

  fifo_rd #(.DW(DW), .AW(AW)) dut (
    .I_RD_CLK      (clk),
    .I_RD_RST      (I_RD_RST),
    .I_RD_WR_PTR   (I_RD_WR_PTR),
    .O_RD_PTR      (O_RD_PTR),
    .O_RD_ADDR     (O_RD_ADDR),
    .O_RD_MEM_EN   (O_RD_MEM_EN),
    .I_RD_MEM_DATA (ram_q),
    .O_RD_DATA     (O_RD_DATA),
    .O_RD_VALID    (O_RD_VALID),
    .I_RD_READY    (I_RD_READY),
    .O_RD_EMPTY    (O_RD_EMPTY),
    .O_RD_LEVEL    (O_RD_LEVEL)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous-read RAM model
  always @(posedge clk) begin
    if (O_RD_MEM_EN) ram_q <= ram[O_RD_ADDR];
  end

  // consumer ready driver
  always @(posedge clk) begin
    #2;
    I_RD_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // ---------------- helpers ----------------
  function automatic logic [AW:0] gray_of(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [DW-1:0] d);
    ram[wr_bin[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_bin = wr_bin + 1'b1;
    wr_total++;
    I_RD_WR_PTR = gray_of(wr_bin);
  endtask

  task automatic do_reset();
    I_RD_RST = 1'b1;
    wr_bin = '0;
    wr_total = 0;
    I_RD_WR_PTR = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    I_RD_RST = 1'b0;
  endtask

  // writes 'total' random words in random bursts, never overfilling memory
  task automatic write_random(input int total);
    int done = 0;
    int guard = 0;
    int k;
    int space;
    while (done < total && guard < 3000) begin
      @(posedge clk);
      #1;
      k = $urandom_range(0, 3);
      if (k > total - done) k = total - done;
      space = DEPTH - (wr_total - pop_cnt);
      if (k > space) k = space;
      for (int i = 0; i < k; i++) write_word(DW'($urandom_range(0, 255)));
      if (k > 0) done += k;
      guard++;
    end
    check("write_random_done", done, total);
  endtask

  task automatic wait_valid(input int budget);
    int t = 0;
    @(negedge clk);
    while (!O_RD_VALID && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_valid_timeout", O_RD_VALID, 1);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ptr"}, O_RD_PTR, gray_of(wr_bin));
    check({tag, "_empty"}, O_RD_EMPTY, 1);
    check({tag, "_level"}, O_RD_LEVEL, 0);
    check({tag, "_valid"}, O_RD_VALID, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (I_RD_RST) begin
      fetch_cnt = 0;
      pop_cnt = 0;
    end else begin
      n_cmp++;
      assert ((fetch_cnt - pop_cnt) >= 0 && (fetch_cnt - pop_cnt) <= 2)
      else begin
        n_mis++;
        $display("FAIL obuf_occupancy: got %0d words held, limit 2", fetch_cnt - pop_cnt);
      end
      if (O_RD_VALID && I_RD_READY) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_word: got %0h, expected no word", O_RD_DATA);
        end else begin
          e = exp_q.pop_front();
          if (O_RD_DATA !== e) begin
            n_mis++;
            $display("FAIL read_data: got %0h, expected %0h", O_RD_DATA, e);
          end
        end
        pop_cnt++;
      end
      if (O_RD_MEM_EN) fetch_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] exp_addr[4];
    bit saw31;
    bit saw32;
    int t;

    // 1: reset state
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_empty", O_RD_EMPTY, 1);
      check("rst_valid", O_RD_VALID, 0);
      check("rst_ptr", O_RD_PTR, 0);
      check("rst_mem_en", O_RD_MEM_EN, 0);
    end
    check("rst_level", O_RD_LEVEL, 0);
    check("rst_data", O_RD_DATA, 0);

    // 2: single word latency
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    write_word(8'hA5);
    t = 0;
    @(negedge clk);
    while (!O_RD_MEM_EN && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("one_mem_en", O_RD_MEM_EN, 1);
    check("one_addr", O_RD_ADDR, 0);
    check("one_valid_early", O_RD_VALID, 0);
    @(negedge clk);
    check("one_ptr", O_RD_PTR, 5'b00001);
    check("one_empty_again", O_RD_EMPTY, 1);
    check("one_valid_n1", O_RD_VALID, 0);
    @(negedge clk);
    check("one_valid_n2", O_RD_VALID, 1);
    check("one_data_n2", O_RD_DATA, 8'hA5);
    wait_drain(50);
    check_idle("one_idle");

    // 3: full-depth streaming at one word per cycle
    do_reset();
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
    wait_valid(20);
    for (int i = 0; i < DEPTH; i++) begin
      check("stream_valid", O_RD_VALID, 1);
      @(negedge clk);
    end
    wait_drain(50);
    check("stream_ptr", O_RD_PTR, 5'b11000);
    check_idle("stream_idle");

    // 4: consumer stalled, then released
    do_reset();
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) write_word(DW'(i));
    repeat (10) @(negedge clk);
    check("stall_fetches", fetch_cnt, 2);
    check("stall_level", O_RD_LEVEL, 6);
    check("stall_ptr", O_RD_PTR, 5'b00011);
    check("stall_empty", O_RD_EMPTY, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_valid", O_RD_VALID, 1);
      check("stall_hold_data", O_RD_DATA, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready_val = 1'b1;
    wait_drain(100);
    check_idle("stall_idle");

    // randomized traffic: advance both pointers to 30
    do_reset();
    rand_ready = 1'b1;
    write_random(30);
    wait_drain(500);
    check_idle("soak_idle");

    // 5: wrap-around of address and pointer
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) write_word(DW'($urandom_range(0, 255)));
    saw31 = 0;
    saw32 = 0;
    t = 0;
    while ((exp_q.size() != 0 || t < 6) && t < 300) begin
      @(negedge clk);
      if (O_RD_MEM_EN) addr_q.push_back(O_RD_ADDR);
      if (O_RD_PTR == 5'b10000) saw31 = 1;
      if (O_RD_PTR == 5'b00000) saw32 = 1;
      t++;
    end
    exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    check("wrap_fetch_count", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check("wrap_addr", addr_q[i], exp_addr[i]);
    check("wrap_saw_gray31", saw31, 1);
    check("wrap_saw_gray32", saw32, 1);
    repeat (3) @(negedge clk);
    check("wrap_ptr", O_RD_PTR, 5'b00011);
    check_idle("wrap_idle");
    rand_ready = 1'b0;

    // 6: asynchronous reset in the middle of a stream
    do_reset();
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) write_word(DW'($urandom_range(0, 255)));
    wait_valid(20);
    repeat (2) @(negedge clk);
    #2;
    I_RD_RST = 1'b1;
    wr_bin = '0;
    wr_total = 0;
    I_RD_WR_PTR = '0;
    exp_q.delete();
    #1;
    check("arst_valid", O_RD_VALID, 0);
    check("arst_data", O_RD_DATA, 0);
    check("arst_empty", O_RD_EMPTY, 1);
    check("arst_ptr", O_RD_PTR, 0);
    check("arst_addr", O_RD_ADDR, 0);
    check("arst_level", O_RD_LEVEL, 0);
    check("arst_mem_en", O_RD_MEM_EN, 0);
    repeat (2) @(posedge clk);
    #1;
    I_RD_RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_valid", O_RD_VALID, 0);
      check("post_rst_mem_en", O_RD_MEM_EN, 0);
    end
    @(posedge clk);
    #1;
    write_word(8'h3C);
    wait_drain(50);
    check_idle("post_rst_idle");

    check("final_queue_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
